vga_digit_renderer: RTL



---
 rtl/vga_digit_renderer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vga_digit_renderer.sv
// Renders eight seven-segment BCD digits inside the VGA write zone, two-stage pixel pipeline
// with delay-matched syncs; new digit values are committed only on a v_sync rising edge.
module vga_digit_renderer #(
  parameter int         START_VERTICAL = 206,
  parameter int         CELL_W         = 42,
  parameter int         CELL_PITCH     = 56,
  parameter int         CELL_H         = 70,
  parameter int         STROKE         = 6,
  parameter logic [2:0] FG_COLOR       = 3'b010,
  parameter logic [2:0] BG_COLOR       = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_zone,
  input  logic [9:0]  count1,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [31:0] upd_digits,
  output logic [2:0]  rgb,
  output logic        h_sync_out,
  output logic        v_sync_out,
  output logic        frame_commit
);

  localparam int CX_W   = $clog2(CELL_PITCH);
  localparam int MID_LO = (CELL_H - STROKE) / 2;
  localparam int MID_HI = MID_LO + STROKE - 1;
  localparam int RIGHT  = CELL_W - STROKE;
  localparam int BOT    = CELL_H - STROKE;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state;
  logic [31:0] pending;
  logic [31:0] display;
  logic        prev_vsync;

  logic [CX_W-1:0] cell_cnt;
  logic [2:0]      digit_cnt;

  logic [CX_W-1:0] cell_x_p1;
  logic [2:0]      digit_p1;
  logic [9:0]      y_p1;
  logic            vld_p1;
  logic            hs_p1;
  logic            vs_p1;

  logic [2:0]      rgb_p2;
  logic            hs_p2;
  logic            vs_p2;

  logic [3:0]      nibble;
  logic            hit;

  // Segment bits are {a,b,c,d,e,f,g}; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  function automatic logic glyph_hit(input logic [6:0] s, input logic [CX_W-1:0] cx,
                                     input logic [9:0] y);
    int   xi;
    int   yi;
    logic in_h;
    logic left;
    logic right;
    logic top;
    logic low;
    xi    = int'(cx);
    yi    = int'(y);
    in_h  = (xi >= STROKE) && (xi < RIGHT);
    left  = (xi < STROKE);
    right = (xi >= RIGHT) && (xi < CELL_W);
    top   = (yi <= MID_HI);
    low   = (yi >= MID_LO) && (yi < CELL_H);
    glyph_hit = (s[6] && in_h && (yi < STROKE)) ||
                (s[5] && right && top) ||
                (s[4] && right && low) ||
                (s[3] && in_h && (yi >= BOT) && (yi < CELL_H)) ||
                (s[2] && left && low) ||
                (s[1] && left && top) ||
                (s[0] && in_h && (yi >= MID_LO) && (yi <= MID_HI));
  endfunction

  function automatic logic [2:0] digit_next(input logic [2:0] d);
    digit_next = (d == 3'd7) ? d : d + 3'd1;
  endfunction

  // Update handshake: capture into pending, publish on the next v_sync rise.
  always_ff @(posedge clk) begin
    prev_vsync <= v_sync;
    if (reset) begin
      state        <= IDLE;
      pending      <= '0;
      display      <= '1;
      upd_ready    <= 1'b1;
      frame_commit <= 1'b0;
    end else begin
      frame_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (upd_valid && upd_ready) begin
            pending   <= upd_digits;
            state     <= PENDING;
            upd_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (v_sync && !prev_vsync) begin
            display      <= pending;
            frame_commit <= 1'b1;
            state        <= IDLE;
            upd_ready    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          upd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Horizontal position as cell offset plus saturating digit index.
  always_ff @(posedge clk) begin
    if (reset || !write_zone) begin
      cell_cnt  <= '0;
      digit_cnt <= '0;
    end else if (cell_cnt == CX_W'(CELL_PITCH - 1)) begin
      cell_cnt  <= '0;
      digit_cnt <= digit_next(digit_cnt);
    end else begin
      cell_cnt  <= cell_cnt + CX_W'(1);
    end
  end

  // ---- stage 1: position / row offset ----
  always_ff @(posedge clk) begin
    cell_x_p1 <= cell_cnt;
    digit_p1  <= digit_cnt;
    y_p1      <= count1 - 10'(START_VERTICAL);
    if (reset) begin
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else begin
      vld_p1 <= write_zone;
      hs_p1  <= h_sync;
      vs_p1  <= v_sync;
    end
  end

  assign nibble = display[{~digit_p1, 2'b00} +: 4];
  assign hit    = glyph_hit(seg_decode(nibble), cell_x_p1, y_p1);

  // ---- stage 2: segment hit / colour ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p2 <= 3'b000;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else begin
      rgb_p2 <= (vld_p1 && hit) ? FG_COLOR : BG_COLOR;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  assign rgb        = rgb_p2;
  assign h_sync_out = hs_p2;
  assign v_sync_out = vs_p2;

endmodule
